// File: rtl/decode_lift_rp.sv
// Post-decoder lifting stage: streams P unsigned radix-decoded coefficients out of the
// decoder BRAM and writes their centred two's-complement representatives to the polynomial RAM.
module decode_lift_rp #(
   parameter int P        = 761,
   parameter int Q        = 4591,
   parameter int D_SIZE   = 13,
   parameter int DEPTH    = 10,
   parameter int OUT_SIZE = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [DEPTH-1:0]    cd_rd_addr,
   input  logic [D_SIZE-1:0]   cd_rd_data,
   output logic [DEPTH-1:0]    poly_wr_addr,
   output logic [OUT_SIZE-1:0] poly_wr_data,
   output logic                poly_wr_en
);

   localparam int EW = D_SIZE + 2;
   localparam logic [EW-1:0]    HALF  = EW'((Q - 1) / 2);
   localparam logic [EW-1:0]    THIRD = EW'((Q - 1) / 3);
   localparam logic [EW-1:0]    QV    = EW'(Q);
   localparam logic [DEPTH-1:0] LAST  = DEPTH'(P - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state_q;
   logic                  mode_q;
   logic [DEPTH-1:0]      addr_q;
   logic                  drain_q;
   logic                  dValid_q;
   logic [DEPTH-1:0]      dAddr_q;
   logic                  wrEn_q;
   logic [DEPTH-1:0]      wrAddr_q;
   logic [OUT_SIZE-1:0]   wrData_q;
   logic                  viol_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;

   logic [EW-1:0]         rExt;
   logic [EW-1:0]         vVal;
   logic [OUT_SIZE-1:0]   liftVal_d;
   logic                  viol_d;

   // Lift the word returned by the BRAM; 3r is formed as r + 2r to avoid a multiplier.
   always_comb begin
      rExt      = EW'(cd_rd_data);
      vVal      = mode_q ? (rExt + (rExt << 1)) : rExt;
      liftVal_d = OUT_SIZE'(vVal - HALF);
      viol_d    = mode_q ? (rExt > THIRD) : (rExt >= QV);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mode_q   <= 1'b0;
         addr_q   <= '0;
         drain_q  <= 1'b0;
         dValid_q <= 1'b0;
         dAddr_q  <= '0;
         wrEn_q   <= 1'b0;
         wrAddr_q <= '0;
         wrData_q <= '0;
         viol_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // Two-stage pipeline: address issued, data returned, then registered write.
         dValid_q <= (state_q == RUN);
         dAddr_q  <= addr_q;
         wrEn_q   <= dValid_q;
         wrAddr_q <= dAddr_q;
         wrData_q <= liftVal_d;
         viol_q   <= dValid_q & viol_d;

         if (state_q == IDLE && start) begin
            err_q <= 1'b0;
         end else if (wrEn_q && viol_q) begin
            err_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  mode_q  <= mode;
                  addr_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (addr_q == LAST) begin
                  addr_q  <= '0;
                  drain_q <= 1'b0;
                  state_q <= DRAIN;
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
            end
            DRAIN: begin
               // One cycle for BRAM latency, one for the output register.
               if (drain_q) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  drain_q <= 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign cd_rd_addr   = addr_q;
   assign poly_wr_addr = wrAddr_q;
   assign poly_wr_data = wrData_q;
   assign poly_wr_en   = wrEn_q;

endmodule

// File: tb/tb_decode_lift_rp.sv
// Randomised bench for decode_lift_rp: a BRAM model feeds the DUT and every cycle of each
// run is compared against expectations computed from the lifting rules.
module tb_decode_lift_rp;

   localparam int P        = 761;
   localparam int Q        = 4591;
   localparam int D_SIZE   = 13;
   localparam int DEPTH    = 10;
   localparam int OUT_SIZE = 14;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic                mode;
   logic                busy;
   logic                done;
   logic                err;
   logic [DEPTH-1:0]    cd_rd_addr;
   logic [D_SIZE-1:0]   cd_rd_data;
   logic [DEPTH-1:0]    poly_wr_addr;
   logic [OUT_SIZE-1:0] poly_wr_data;
   logic                poly_wr_en;

   logic [D_SIZE-1:0]   mem [0:(1<<DEPTH)-1];

   int totalChecks = 0;
   int badChecks   = 0;

   decode_lift_rp #(
      .P(P), .Q(Q), .D_SIZE(D_SIZE), .DEPTH(DEPTH), .OUT_SIZE(OUT_SIZE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mode         (mode),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .cd_rd_addr   (cd_rd_addr),
      .cd_rd_data   (cd_rd_data),
      .poly_wr_addr (poly_wr_addr),
      .poly_wr_data (poly_wr_data),
      .poly_wr_en   (poly_wr_en)
   );

   always #5 clk = ~clk;

   // Synchronous-read BRAM: data follows the address by one clock.
   always @(posedge clk) cd_rd_data <= mem[cd_rd_addr];

   task automatic checkOutput(input string tag, input int observed, input int expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Centred value v - (Q-1)/2, wrapped into OUT_SIZE-bit two's complement.
   function automatic int liftRef(input int r, input bit m);
      int v;
      int x;
      int span;
      span = 1 << OUT_SIZE;
      v = m ? 3 * r : r;
      x = v - (Q - 1) / 2;
      x = ((x % span) + span) % span;
      if (x >= span / 2) x = x - span;
      return x;
   endfunction

   function automatic bit violRef(input int r, input bit m);
      return m ? (r > (Q - 1) / 3) : (r >= Q);
   endfunction

   task automatic fillRandom(input bit m, input bit allowViol);
      for (int i = 0; i < (1 << DEPTH); i++) begin
         if (m) mem[i] = D_SIZE'($urandom_range(0, (Q - 1) / 3));
         else   mem[i] = D_SIZE'($urandom_range(0, Q - 1));
         if (allowViol && $urandom_range(0, 99) == 0) begin
            if (m) mem[i] = D_SIZE'($urandom_range((Q - 1) / 3 + 1, (1 << D_SIZE) - 1));
            else   mem[i] = D_SIZE'($urandom_range(Q, (1 << D_SIZE) - 1));
         end
      end
   endtask

   // One full run starting in the current (IDLE) cycle; returns in cycle P+4.
   task automatic applyStimulus(input bit runMode, input bit toggleMode, input bit strayStarts);
      bit errExp;
      errExp = 1'b0;
      mode  = runMode;
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      for (int k = 1; k <= P + 3; k++) begin
         checkOutput("busy", int'(busy), 1);
         checkOutput("done", int'(done), int'(k == P + 3));
         if (k <= P) checkOutput("rdAddr", int'(cd_rd_addr), k - 1);
         checkOutput("wrEn", int'(poly_wr_en), int'(k >= 3 && k <= P + 2));
         if (k >= 3 && k <= P + 2) begin
            checkOutput("wrAddr", int'(poly_wr_addr), k - 3);
            checkOutput("wrData", int'($signed(poly_wr_data)), liftRef(int'(mem[k - 3]), runMode));
         end
         if (k >= 4 && violRef(int'(mem[k - 4]), runMode)) errExp = 1'b1;
         checkOutput("err", int'(err), int'(errExp));
         if (toggleMode) mode = ~mode;
         start = strayStarts && (k == 50 || k == P + 3);
         nextCycle();
      end
      start = 1'b0;
      checkOutput("busyEnd", int'(busy), 0);
      checkOutput("doneEnd", int'(done), 0);
      checkOutput("wrEnEnd", int'(poly_wr_en), 0);
      checkOutput("errEnd", int'(err), int'(errExp));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Busy"}, int'(busy), 0);
      checkOutput({tag, "Done"}, int'(done), 0);
      checkOutput({tag, "Err"}, int'(err), 0);
      checkOutput({tag, "RdAddr"}, int'(cd_rd_addr), 0);
      checkOutput({tag, "WrAddr"}, int'(poly_wr_addr), 0);
      checkOutput({tag, "WrData"}, int'(poly_wr_data), 0);
      checkOutput({tag, "WrEn"}, int'(poly_wr_en), 0);
   endtask

   // Reset asserted in cycle 100 of a run: outputs clear and nothing further is written.
   task automatic resetRun();
      int writes;
      int dones;
      writes = 0;
      dones  = 0;
      fillRandom(1'b0, 1'b1);
      mem[7] = D_SIZE'(Q + 3);
      mode  = 1'b0;
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      for (int k = 1; k < 100; k++) nextCycle();
      checkOutput("preRstErr", int'(err), 1);
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      checkAllZero("midRst");
      for (int k = 0; k < P + 10; k++) begin
         writes += int'(poly_wr_en);
         dones  += int'(done);
         nextCycle();
      end
      checkOutput("postRstWrites", writes, 0);
      checkOutput("postRstDones", dones, 0);
      checkOutput("postRstBusy", int'(busy), 0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      for (int i = 0; i < (1 << DEPTH); i++) mem[i] = '0;
      repeat (3) nextCycle();
      checkAllZero("reset");
      rst = 1'b0;
      nextCycle();

      $display("[TB] Rq lift, directed endpoints");
      fillRandom(1'b0, 1'b0);
      mem[0] = 13'd0;
      mem[1] = 13'd2295;
      mem[2] = 13'd4590;
      applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] Rounded lift, directed endpoints");
      fillRandom(1'b1, 1'b0);
      mem[0]   = 13'd0;
      mem[1]   = 13'd765;
      mem[760] = 13'd1530;
      applyStimulus(1'b1, 1'b0, 1'b0);

      $display("[TB] Rq range error, sticky until next start");
      fillRandom(1'b0, 1'b0);
      mem[5] = 13'd4591;
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (5) nextCycle();
      checkOutput("errSticky", int'(err), 1);

      $display("[TB] Rounded range error with stray starts and mode toggling");
      fillRandom(1'b1, 1'b0);
      mem[5] = 13'd1531;
      applyStimulus(1'b1, 1'b1, 1'b1);

      $display("[TB] Back-to-back random runs");
      fillRandom(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      fillRandom(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);

      $display("[TB] Reset mid-run, then a full run");
      resetRun();
      fillRandom(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
